// File: rtl/out_res_pack_if.sv
`default_nettype none
// ============================================================================
//  Module      : out_res_pack_if
//  Description : Operand-in / packed-result-out handshake bundle for out_res_pack
//  Revision    : 1.0 - initial release
// ============================================================================
interface out_res_pack_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic [EXP_W:0]         in_exp1;
    logic [EXP_W:0]         in_exp2;
    logic [2*MAN_W+1:0]     in_mant_prod;
    logic                   in_valid;
    logic                   in_ready;
    logic [EXP_W+MAN_W:0]   out_result;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_ovf;
    logic                   out_unf;

    modport master (
        output in_exp1, in_exp2, in_mant_prod, in_valid, out_ready,
        input  in_ready, out_result, out_valid, out_ovf, out_unf
    );

    modport slave (
        input  in_exp1, in_exp2, in_mant_prod, in_valid, out_ready,
        output in_ready, out_result, out_valid, out_ovf, out_unf
    );
endinterface
`default_nettype wire

// File: rtl/out_res_pack.sv
`default_nettype none
// ============================================================================
//  Module      : out_res_pack
//  Description : Sign/exponent rebias, normalise and IEEE-754 single packing
//                of a multiplier result, held under a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_res_pack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  wire logic           clk,
    input  wire logic           clr,
    out_res_pack_if.slave       bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXP  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic signed [EXP_W+1:0] c_BIAS    = (EXP_W+2)'(BIAS);
    localparam logic signed [EXP_W+1:0] c_ONE     = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] c_EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;

    logic                       r_s1;
    logic                       r_s2;
    logic [EXP_W-1:0]           r_e1;
    logic [EXP_W-1:0]           r_e2;
    logic [MAN_W+1:0]           r_prod_hi;

    logic                       r_sign;
    logic                       r_zero;
    logic signed [EXP_W+1:0]    r_esum;

    logic [EXP_W+MAN_W:0]       r_result;
    logic                       r_valid;
    logic                       r_ovf;
    logic                       r_unf;

    logic signed [EXP_W+1:0]    w_esum;
    logic signed [EXP_W+1:0]    w_efin;
    logic [MAN_W-1:0]           w_mant;
    logic                       w_ovf;
    logic                       w_unf;
    logic                       w_accept;
    logic                       w_unused;

    // Product bits below the kept mantissa window are truncated away.
    assign w_unused = &{1'b0, bus.in_mant_prod[MAN_W-1:0]};

    assign w_accept = (r_state == ST_IDLE) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_EXP;
            ST_EXP:                     w_state_nxt = ST_NORM;
            ST_NORM:                    w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_esum = $signed({2'b00, r_e1}) + $signed({2'b00, r_e2}) - c_BIAS;

    // A product >= 2.0 carries into the top bit and needs one extra exponent step.
    assign w_efin = r_prod_hi[MAN_W+1] ? (r_esum + c_ONE) : r_esum;
    assign w_mant = r_prod_hi[MAN_W+1] ? r_prod_hi[MAN_W:1] : r_prod_hi[MAN_W-1:0];
    assign w_ovf  = (w_efin >= c_EXP_MAX);
    assign w_unf  = w_efin[EXP_W+1] || (w_efin == '0);

    // Operand capture and exponent stage; cleared state is never observed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1      <= bus.in_exp1[EXP_W];
            r_s2      <= bus.in_exp2[EXP_W];
            r_e1      <= bus.in_exp1[EXP_W-1:0];
            r_e2      <= bus.in_exp2[EXP_W-1:0];
            r_prod_hi <= bus.in_mant_prod[2*MAN_W+1:MAN_W];
        end
        if (r_state == ST_EXP) begin
            r_sign <= r_s1 ^ r_s2;
            r_zero <= (r_e1 == '0) || (r_e2 == '0);
            r_esum <= w_esum;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (r_state == ST_NORM) begin
            r_valid <= 1'b1;
            if (r_zero) begin
                r_result <= {r_sign, {(EXP_W+MAN_W){1'b0}}};
                r_ovf    <= 1'b0;
                r_unf    <= 1'b0;
            end else if (w_ovf) begin
                r_result <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                r_ovf    <= 1'b1;
                r_unf    <= 1'b0;
            end else if (w_unf) begin
                r_result <= {r_sign, {(EXP_W+MAN_W){1'b0}}};
                r_ovf    <= 1'b0;
                r_unf    <= 1'b1;
            end else begin
                r_result <= {r_sign, w_efin[EXP_W-1:0], w_mant};
                r_ovf    <= 1'b0;
                r_unf    <= 1'b0;
            end
        end else if ((r_state == ST_DONE) && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = (r_state == ST_IDLE);
    assign bus.out_result = r_result;
    assign bus.out_valid  = r_valid;
    assign bus.out_ovf    = r_ovf;
    assign bus.out_unf    = r_unf;

endmodule
`default_nettype wire
